uart_tx: RTL and testbench

// - UART transmitter; counterpart of the controller's receive path, sharing its cfg_div/cfg_nstop settings.
// - Serialises 8-bit bytes as 1 start bit (0), 8 data bits (LSb first), then 1 or 2 stop bits (1). No parity.
// - One-entry holding buffer, so the next byte can be accepted while the current byte shifts out.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_baud.sv | 47 ++++
 rtl/uart_tx.sv | 136 +++++++++++++
 tb/tb_uart_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the tx/rx FSM state encodings.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_e;

endpackage

// File: rtl/uart_tx_baud.sv
// Bit-time generator: tick divider followed by an oversample counter; bit_end_o marks the
// last tick of each bit. Both counters are held at zero while clr_i is set.
module uart_tx_baud #(
    parameter int unsigned Oversample = uart_pkg::OVERSAMPLE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic [15:0] div_i,
    output logic        bit_end_o
);

    localparam int unsigned CntW = $clog2(Oversample);

    logic [15:0]     tick_cnt_q, tick_cnt_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic            tick;
    logic            last_tick;

    assign tick      = !clr_i && (tick_cnt_q == div_i);
    assign last_tick = (bit_cnt_q == CntW'(Oversample - 1));
    assign bit_end_o = tick && last_tick;

    always_comb begin
        tick_cnt_d = tick_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        if (clr_i || tick) begin
            tick_cnt_d = '0;
        end
        if (clr_i) begin
            bit_cnt_d = '0;
        end else if (tick) begin
            bit_cnt_d = last_tick ? '0 : bit_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding buffer feeding a start/data/stop serialiser with a
// registered, glitch-free line output.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned Oversample = OVERSAMPLE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cfg_div,
    input  logic        cfg_txen,
    input  logic        cfg_nstop,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        tx_busy,
    output logic        uart_txd
);

    localparam int unsigned DcntW = $clog2(DATA_BITS);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic                 hold_vld_q, hold_vld_d;
    logic [DcntW-1:0]     data_cnt_q, data_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 txd_q, txd_d;
    logic                 hold_clr;
    logic                 accept;
    logic                 bit_end;

    uart_tx_baud #(
        .Oversample (Oversample)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == TxIdle),
        .div_i     (cfg_div),
        .bit_end_o (bit_end)
    );

    assign tx_ready = !hold_vld_q;
    assign tx_busy  = (state_q != TxIdle) || hold_vld_q;
    assign uart_txd = txd_q;
    assign accept   = tx_valid && tx_ready;

    // accept only happens with an empty buffer, so it can never collide with a load
    always_comb begin
        hold_data_d = hold_data_q;
        hold_vld_d  = hold_vld_q;
        if (accept) begin
            hold_data_d = tx_data;
            hold_vld_d  = 1'b1;
        end else if (hold_clr) begin
            hold_vld_d  = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        data_cnt_d = data_cnt_q;
        stop_cnt_d = stop_cnt_q;
        hold_clr   = 1'b0;
        unique case (state_q)
            TxIdle: begin
                if (hold_vld_q && cfg_txen) begin
                    shift_d  = hold_data_q;
                    hold_clr = 1'b1;
                    state_d  = TxStart;
                end
            end
            TxStart: begin
                if (bit_end) begin
                    data_cnt_d = '0;
                    state_d    = TxData;
                end
            end
            TxData: begin
                if (bit_end) begin
                    shift_d    = {1'b0, shift_q[DATA_BITS-1:1]};
                    data_cnt_d = data_cnt_q + DcntW'(1);
                    if (data_cnt_q == DcntW'(DATA_BITS - 1)) begin
                        stop_cnt_d = 1'b0;
                        state_d    = TxStop;
                    end
                end
            end
            TxStop: begin
                if (bit_end) begin
                    if (stop_cnt_q == cfg_nstop) begin
                        // chain straight into the next frame when a byte is waiting
                        if (hold_vld_q && cfg_txen) begin
                            shift_d  = hold_data_q;
                            hold_clr = 1'b1;
                            state_d  = TxStart;
                        end else begin
                            state_d  = TxIdle;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = TxIdle;
        endcase

        unique case (state_d)
            TxStart: txd_d = 1'b0;
            TxData:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TxIdle;
            shift_q     <= '0;
            hold_data_q <= '0;
            hold_vld_q  <= 1'b0;
            data_cnt_q  <= '0;
            stop_cnt_q  <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_data_q <= hold_data_d;
            hold_vld_q  <= hold_vld_d;
            data_cnt_q  <= data_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            txd_q       <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of single frames, hand-written corner sequences and
// a loopback against a bench-side serial receiver.
module tb_uart_tx;

    logic        clk;
    logic        rst_n;
    logic [15:0] cfg_div;
    logic        cfg_txen;
    logic        cfg_nstop;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        uart_txd;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_div   (cfg_div),
        .cfg_txen  (cfg_txen),
        .cfg_nstop (cfg_nstop),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .uart_txd  (uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bits: line levels in transmit order, first bit in bit 10
    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        logic        nstop;
        logic [10:0] bits;
        int          len;
    } vec_t;

    vec_t        vecs[4];
    logic [7:0]  sent_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic offer(input logic [7:0] d);
        int guard = 0;
        while (!tx_ready && guard < 5000) begin
            tick(1);
            guard++;
        end
        check("offer_ready", tx_ready, 1);
        tx_valid = 1'b1;
        tx_data  = d;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // Entered at t=skip cycles into the start bit; samples each bit mid-way and returns at the
    // cycle just after the last bit (t = nbits*T).
    task automatic check_frame(input string name, input logic [10:0] bits, input int nbits,
                               input int t_bit, input int skip);
        tick(t_bit / 2 - skip);
        for (int k = 0; k < nbits; k++) begin
            if (k > 0) tick(t_bit);
            check($sformatf("%s_bit%0d", name, k), uart_txd, bits[10-k]);
        end
        tick(t_bit / 2);
    endtask

    task automatic watch_idle(input string name, input int n);
        int lows = 0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (uart_txd !== 1'b1) lows++;
        end
        check(name, lows, 0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, div: 16'd0, nstop: 1'b0, bits: 11'b01010010111, len: 160};
        vecs[1] = '{data: 8'h00, div: 16'd3, nstop: 1'b1, bits: 11'b00000000011, len: 704};
        vecs[2] = '{data: 8'h81, div: 16'd1, nstop: 1'b0, bits: 11'b01000000111, len: 320};
        vecs[3] = '{data: 8'h6B, div: 16'd0, nstop: 1'b1, bits: 11'b01101011011, len: 176};

        rst_n     = 1'b0;
        cfg_div   = 16'd0;
        cfg_txen  = 1'b1;
        cfg_nstop = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        tick(3);
        check("reset_txd", uart_txd, 1);
        check("reset_ready", tx_ready, 1);
        check("reset_busy", tx_busy, 0);
        rst_n = 1'b1;
        tick(3);

        // single frames from the table
        for (int v = 0; v < 4; v++) begin
            int t_bit;
            int busy_len;
            t_bit     = 16 * (int'(vecs[v].div) + 1);
            cfg_div   = vecs[v].div;
            cfg_nstop = vecs[v].nstop;
            offer(vecs[v].data);
            check($sformatf("v%0d_accept_txd", v), uart_txd, 1);
            check($sformatf("v%0d_accept_ready", v), tx_ready, 0);
            check($sformatf("v%0d_accept_busy", v), tx_busy, 1);
            tick(1);
            check($sformatf("v%0d_latency", v), uart_txd, 0);
            check_frame($sformatf("v%0d", v), vecs[v].bits, 10 + int'(vecs[v].nstop), t_bit, 0);
            busy_len = (10 + int'(vecs[v].nstop)) * t_bit;
            check($sformatf("v%0d_len", v), busy_len, vecs[v].len);
            check($sformatf("v%0d_busy_end", v), tx_busy, 0);
            check($sformatf("v%0d_txd_end", v), uart_txd, 1);
            tick(5);
        end

        // back-to-back 0x55 then 0x0F
        cfg_div   = 16'd0;
        cfg_nstop = 1'b0;
        tx_valid  = 1'b1;
        tx_data   = 8'h55;
        tick(1);
        tx_data = 8'h0F;
        check("b2b_ready_before_load", tx_ready, 0);
        tick(1);
        check("b2b_first_start", uart_txd, 0);
        check("b2b_ready_after_load", tx_ready, 1);
        tick(1);
        tx_valid = 1'b0;
        check("b2b_second_held", tx_ready, 0);
        check_frame("b2b_first", 11'b01010101011, 10, 16, 1);
        check("b2b_no_gap", uart_txd, 0);
        check("b2b_busy_mid", tx_busy, 1);
        check("b2b_ready_second_loaded", tx_ready, 1);
        check_frame("b2b_second", 11'b01111000011, 10, 16, 0);
        check("b2b_busy_end", tx_busy, 0);
        tick(5);

        // byte held while transmit disabled
        cfg_txen = 1'b0;
        offer(8'h3C);
        check("txen_ready", tx_ready, 0);
        check("txen_busy", tx_busy, 1);
        watch_idle("txen_line_idle", 40);
        cfg_txen = 1'b1;
        tick(1);
        check("txen_start", uart_txd, 0);
        check_frame("txen_frame", 11'b00011110011, 10, 16, 0);
        check("txen_busy_end", tx_busy, 0);
        tick(5);

        // asynchronous reset during data bit 4 of 0xFF, with a second byte pending
        offer(8'hFF);
        tick(1);
        check("rst_start", uart_txd, 0);
        offer(8'h12);
        check("rst_pending", tx_ready, 0);
        tick(87);
        check("rst_data_bit4", uart_txd, 1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_async_txd", uart_txd, 1);
        check("rst_async_ready", tx_ready, 1);
        check("rst_async_busy", tx_busy, 0);
        tick(2);
        rst_n = 1'b1;
        watch_idle("rst_line_idle", 50);
        check("rst_busy_after", tx_busy, 0);

        // loopback against a bench-side receiver
        cfg_div = 16'd1;
        for (int ns = 0; ns < 2; ns++) begin
            cfg_nstop = ns[0];
            fork
                begin
                    for (int i = 0; i < 64; i++) begin
                        logic [7:0] b;
                        b = 8'($urandom_range(0, 255));
                        offer(b);
                        sent_q.push_back(b);
                    end
                end
                begin
                    for (int i = 0; i < 64; i++) begin
                        int         guard;
                        logic [7:0] rx;
                        guard = 0;
                        while (uart_txd !== 1'b0 && guard < 2000) begin
                            tick(1);
                            guard++;
                        end
                        if (guard >= 2000) begin
                            check("lb_start_timeout", guard, 0);
                            break;
                        end
                        tick(16);
                        check("lb_start_bit", uart_txd, 0);
                        for (int k = 0; k < 8; k++) begin
                            tick(32);
                            rx[k] = uart_txd;
                        end
                        tick(32);
                        check("lb_stop_bit", uart_txd, 1);
                        if (sent_q.size() == 0) begin
                            check("lb_extra_frame", 1, 0);
                        end else begin
                            check($sformatf("lb_ns%0d_byte%0d", ns, i), rx, sent_q.pop_front());
                        end
                    end
                end
            join
            begin
                int guard = 0;
                while (tx_busy && guard < 200) begin
                    tick(1);
                    guard++;
                end
            end
            check("lb_busy_end", tx_busy, 0);
            check("lb_queue_empty", sent_q.size(), 0);
            watch_idle("lb_no_extra", 100);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
